// File: rtl/writeback_commit_arb.sv
// Writeback commit arbiter: merges per-unit commit beats into one registered writeback stream.
// Round-robin between packets; a multi-beat packet (sop..eop) holds the grant until its eop beat.
module writeback_commit_arb #(
  parameter int NUM_INPUTS  = 4,
  parameter int UUID_WIDTH  = 44,
  parameter int ISSUE_WIS_W = 2,
  parameter int THREAD_CNT  = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int DATAW       = UUID_WIDTH + ISSUE_WIS_W + THREAD_CNT + XLEN + NR_BITS
                              + THREAD_CNT * XLEN + 2,
  parameter int PERF_W      = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        wb_valid,
  output logic [DATAW-1:0]            wb_data,
  output logic [PERF_W-1:0]           perf_stalls
);

  // state    | meaning
  // UNLOCKED | between packets, round-robin from rr_ptr
  // LOCKED   | mid-packet, only lock_id may be granted
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  lock_id, lock_id_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;

  logic                  grant_any;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_INPUTS-1:0] grant_vec;
  logic [DATAW-1:0]      sel_beat;
  logic                  beat_sop, beat_eop;
  logic                  stall;
  int                    scan_idx;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (state == LOCKED) begin
      grant_idx = lock_id;
      grant_any = in_valid[lock_id];
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        scan_idx = (int'(rr_ptr) + k) % NUM_INPUTS;
        if (!grant_any && in_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(scan_idx);
        end
      end
    end
    // Gated by reset so nothing is accepted while the arbiter is held in reset.
    grant_any = grant_any && reset_n;
  end

  always_comb begin
    grant_vec = '0;
    if (grant_any) grant_vec = NUM_INPUTS'(1) << grant_idx;
  end

  assign in_ready = grant_vec;
  assign sel_beat = in_data[grant_idx*DATAW +: DATAW];
  assign beat_sop = sel_beat[1];
  assign beat_eop = sel_beat[0];
  // Covers both "valid but nothing granted" and "granted while someone else waits".
  assign stall    = |(in_valid & ~grant_vec);

  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    rr_ptr_nxt  = rr_ptr;
    case (state)
      UNLOCKED: begin
        if (grant_any && !beat_eop) begin
          state_nxt   = LOCKED;
          lock_id_nxt = grant_idx;
        end
      end
      LOCKED: begin
        if (grant_any && beat_eop) state_nxt = UNLOCKED;
      end
      default: state_nxt = UNLOCKED;
    endcase
    if (grant_any && beat_eop)
      rr_ptr_nxt = IDX_W'((int'(grant_idx) + 1) % NUM_INPUTS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= UNLOCKED;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      perf_stalls <= '0;
    end else begin
      wb_valid <= grant_any;
      if (grant_any) wb_data <= sel_beat;
      if (stall && (perf_stalls != {PERF_W{1'b1}}))
        perf_stalls <= perf_stalls + PERF_W'(1);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      assert ($onehot0(in_ready))
        else $error("writeback_commit_arb: in_ready not one-hot-or-zero (%b)", in_ready);
      if (grant_any && state == LOCKED && grant_idx == lock_id)
        assert (!beat_sop)
          else $error("writeback_commit_arb: sop beat from source %0d inside open packet", grant_idx);
      if (grant_any && state == UNLOCKED)
        assert (beat_sop)
          else $error("writeback_commit_arb: beat without sop from source %0d outside packet", grant_idx);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_commit_arb.sv
// Directed bench for writeback_commit_arb: round-robin, packet lock, bubbles, latency, reset, saturation.
module tb_writeback_commit_arb;

  localparam int N  = 4;
  localparam int UW = 4;
  localparam int WW = 2;
  localparam int TC = 4;
  localparam int XL = 16;
  localparam int NB = 5;
  localparam int DW = UW + WW + TC + XL + NB + TC * XL + 2;

  localparam int RD_LO    = 2 + TC * XL;
  localparam int PC_LO    = RD_LO + NB;
  localparam int TMASK_LO = PC_LO + XL;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready, in_ready_sat;
  logic              wb_valid, wb_valid_sat;
  logic [DW-1:0]     wb_data, wb_data_sat;
  logic [31:0]       perf_stalls;
  logic [3:0]        perf_sat;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] p0;
  logic [DW-1:0] hold_beat;

  writeback_commit_arb #(
    .NUM_INPUTS(N), .UUID_WIDTH(UW), .ISSUE_WIS_W(WW), .THREAD_CNT(TC),
    .XLEN(XL), .NR_BITS(NB), .PERF_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wb_valid(wb_valid), .wb_data(wb_data),
    .perf_stalls(perf_stalls)
  );

  writeback_commit_arb #(
    .NUM_INPUTS(N), .UUID_WIDTH(UW), .ISSUE_WIS_W(WW), .THREAD_CNT(TC),
    .XLEN(XL), .NR_BITS(NB), .PERF_W(4)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_sat), .wb_valid(wb_valid_sat), .wb_data(wb_data_sat),
    .perf_stalls(perf_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] mk(input logic [TC-1:0] tmask, input logic [XL-1:0] pc,
                                       input logic [NB-1:0] rd, input logic sop, input logic eop);
    logic [TC*XL-1:0] lanes;
    lanes = {TC{pc ^ 16'h5a5a}};
    return {UW'(pc[3:0]), WW'(2'b01), tmask, pc, rd, lanes, sop, eop};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_singles;
    for (int i = 0; i < N; i++)
      in_data[i*DW +: DW] = mk(4'hF, XL'(16'h100 * i), NB'(i), 1'b1, 1'b1);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = '0;
    in_data  = '0;
    #2;
    chk("rst_ready", in_ready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_perf", perf_stalls, 0);
    tick;
    reset_n = 1'b1;

    // Round-robin over single-beat packets from all sources.
    load_singles();
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", in_ready, 128'(1) << (k % 4));
      tick;
      chk("rr_wb_valid", wb_valid, 1);
      chk("rr_pc", wb_data[PC_LO +: XL], 128'(16'h100 * (k % 4)));
      chk("rr_perf", perf_stalls, 128'(k + 1));
    end

    // Asynchronous reset in the middle of traffic.
    #2;
    reset_n = 1'b0;
    #1;
    chk("amid_ready", in_ready, 0);
    chk("amid_wb_valid", wb_valid, 0);
    chk("amid_perf", perf_stalls, 0);
    chk("amid_wb_data", wb_data, 0);
    tick;
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 4'b0001);
    tick;
    chk("post_rst_pc", wb_data[PC_LO +: XL], 0);
    in_valid = '0;

    // Single beat on input 0: latency 1 and hold afterwards.
    hold_beat = mk(4'b1010, 16'h0040, 5'd5, 1'b1, 1'b1);
    in_data[0 +: DW] = hold_beat;
    in_valid = 4'b0001;
    #1;
    chk("hold_ready", in_ready, 4'b0001);
    tick;
    in_valid = '0;
    chk("hold_wb_valid", wb_valid, 1);
    chk("hold_rd", wb_data[RD_LO +: NB], 5);
    chk("hold_tmask", wb_data[TMASK_LO +: TC], 4'b1010);
    tick;
    chk("hold_wb_idle", wb_valid, 0);
    chk("hold_wb_data", wb_data, hold_beat);

    // Three-beat packet on input 2 with inputs 0 and 3 competing (rr_ptr is 1).
    load_singles();
    in_valid = 4'b1101;
    for (int j = 0; j < 3; j++) begin
      in_data[2*DW +: DW] = mk(4'hF, XL'(16'h200 + j), 5'd2, (j == 0), (j == 2));
      #1;
      chk("lock_ready", in_ready, 4'b0100);
      tick;
      chk("lock_pc", wb_data[PC_LO +: XL], 128'(16'h200 + j));
    end
    #1;
    chk("after_lock_ready", in_ready, 4'b1000);
    tick;
    chk("after_lock_pc", wb_data[PC_LO +: XL], 16'h300);
    in_valid = '0;

    // Locked bubble: input 1 opens a packet, then goes idle for two cycles.
    in_data[1*DW +: DW] = mk(4'hF, 16'h0110, 5'd1, 1'b1, 1'b0);
    in_valid = 4'b0010;
    #1;
    chk("bub_open_ready", in_ready, 4'b0010);
    tick;
    chk("bub_open_wb", wb_valid, 1);
    p0 = perf_stalls;
    in_valid = 4'b0001;
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("bub_ready", in_ready, 0);
      tick;
      chk("bub_wb_valid", wb_valid, 0);
    end
    chk("bub_perf", perf_stalls, 128'(p0 + 2));
    in_data[1*DW +: DW] = mk(4'hF, 16'h0111, 5'd1, 1'b0, 1'b1);
    in_valid = 4'b0011;
    #1;
    chk("bub_eop_ready", in_ready, 4'b0010);
    tick;
    chk("bub_eop_pc", wb_data[PC_LO +: XL], 16'h0111);
    in_valid = 4'b0001;
    #1;
    chk("bub_next_ready", in_ready, 4'b0001);
    tick;
    chk("bub_next_pc", wb_data[PC_LO +: XL], 0);
    in_valid = '0;

    // Sustained contention: narrow counter must pin at all-ones.
    load_singles();
    in_valid = 4'b1111;
    p0 = perf_stalls;
    for (int j = 0; j < 20; j++) tick;
    chk("sat_perf4", perf_sat, 4'hF);
    chk("sat_perf32", perf_stalls, 128'(p0 + 20));
    in_valid = '0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
